// File: rtl/run_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : run_ctrl_multi
// Purpose  : Run-control sequencer (OFF/IDLE/ARMING/RUNNING/DRAINING) driving
//            frame-aligned per-channel FIFO write enables.
// Revision : 1.0
// ============================================================================
module run_ctrl_multi #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 16,
    parameter int VETO_CYCLES  = 4000,
    parameter int DRAIN_CYCLES = 65535,
    parameter bit FRAME_ALIGN  = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic            rst_pulse_i,
    input  logic            init_pulse_i,
    input  logic            start_pulse_i,
    input  logic            stop_pulse_i,
    input  logic [N_CH-1:0] ch_mask_i,
    input  logic [N_CH-1:0] frame_end_i,
    output logic [2:0]      state_o,
    output logic [N_CH-1:0] fifo_wr_en_o,
    output logic            rst_sig_o,
    output logic            rst_sig_pulse_o,
    output logic            drain_to_o
);

    localparam logic [2:0] c_ST_OFF      = 3'b000;
    localparam logic [2:0] c_ST_IDLE     = 3'b001;
    localparam logic [2:0] c_ST_ARMING   = 3'b010;
    localparam logic [2:0] c_ST_RUNNING  = 3'b011;
    localparam logic [2:0] c_ST_DRAINING = 3'b100;

    localparam logic [CNT_W-1:0] c_VETO_LAST  = CNT_W'(VETO_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic [N_CH-1:0]  en_q, en_d;
    logic             drain_to_q, drain_to_d;
    logic             rst_sig_q, rst_sig_pulse_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= c_ST_OFF;
            cnt_q           <= '0;
            mask_q          <= '0;
            en_q            <= '0;
            drain_to_q      <= 1'b0;
            rst_sig_q       <= 1'b0;
            rst_sig_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            mask_q          <= mask_d;
            en_q            <= en_d;
            drain_to_q      <= drain_to_d;
            rst_sig_q       <= rst_i | start_i | stop_i;
            rst_sig_pulse_q <= rst_pulse_i | start_pulse_i | stop_pulse_i;
        end
    end

    // Next-state logic: the highest-priority pulse that applies in the current
    // state wins; otherwise the state's own counting/frame behaviour runs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        en_d       = en_q;
        drain_to_d = drain_to_q;

        if (rst_pulse_i) begin
            state_d = c_ST_IDLE;
            en_d    = '0;
            cnt_d   = '0;
        end else if (stop_pulse_i && state_q == c_ST_ARMING) begin
            state_d = c_ST_IDLE;
            cnt_d   = '0;
        end else if (stop_pulse_i && state_q == c_ST_RUNNING) begin
            state_d = c_ST_DRAINING;
            cnt_d   = '0;
        end else if (start_pulse_i && !stop_pulse_i) begin
            state_d    = c_ST_ARMING;
            mask_d     = ch_mask_i;
            cnt_d      = '0;
            drain_to_d = 1'b0;
            en_d       = '0;
        end else if (init_pulse_i && !stop_pulse_i && !start_pulse_i
                     && state_q == c_ST_OFF) begin
            state_d = c_ST_IDLE;
        end else begin
            case (state_q)
                c_ST_ARMING: begin
                    if (cnt_q == c_VETO_LAST) begin
                        state_d = c_ST_RUNNING;
                        cnt_d   = '0;
                        if (!FRAME_ALIGN) en_d = mask_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                c_ST_RUNNING: begin
                    if (FRAME_ALIGN) en_d = en_q | (frame_end_i & mask_q);
                    else             en_d = mask_q;
                end
                c_ST_DRAINING: begin
                    if (en_q == '0) begin
                        state_d = c_ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == c_DRAIN_LAST) begin
                        state_d    = c_ST_IDLE;
                        cnt_d      = '0;
                        en_d       = '0;
                        drain_to_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        en_d  = en_q & ~frame_end_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are straight from registers
    always_comb begin
        state_o         = state_q;
        fifo_wr_en_o    = en_q;
        rst_sig_o       = rst_sig_q;
        rst_sig_pulse_o = rst_sig_pulse_q;
        drain_to_o      = drain_to_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_ctrl_multi
// Purpose  : Directed self-checking bench for run_ctrl_multi (aligned and
//            unaligned variants driven from shared stimulus).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_run_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_l = 1'b0, start_l = 1'b0, stop_l = 1'b0;
    logic       rst_p = 1'b0, init_p = 1'b0, start_p = 1'b0, stop_p = 1'b0;
    logic [3:0] mask = 4'b0000, fe = 4'b0000;

    logic [2:0] st,  st0;
    logic [3:0] en,  en0;
    logic       rs,  rs0, rsp, rsp0, dto, dto0;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    run_ctrl_multi #(.N_CH(4), .CNT_W(16), .VETO_CYCLES(8), .DRAIN_CYCLES(16),
                     .FRAME_ALIGN(1'b1)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .rst_i(rst_l), .start_i(start_l), .stop_i(stop_l),
        .rst_pulse_i(rst_p), .init_pulse_i(init_p), .start_pulse_i(start_p),
        .stop_pulse_i(stop_p), .ch_mask_i(mask), .frame_end_i(fe),
        .state_o(st), .fifo_wr_en_o(en), .rst_sig_o(rs), .rst_sig_pulse_o(rsp),
        .drain_to_o(dto));

    run_ctrl_multi #(.N_CH(4), .CNT_W(16), .VETO_CYCLES(8), .DRAIN_CYCLES(16),
                     .FRAME_ALIGN(1'b0)) u_dut_na (
        .clk_i(clk), .rst_n_i(rst_n), .rst_i(rst_l), .start_i(start_l), .stop_i(stop_l),
        .rst_pulse_i(rst_p), .init_pulse_i(init_p), .start_pulse_i(start_p),
        .stop_pulse_i(stop_p), .ch_mask_i(mask), .frame_end_i(fe),
        .state_o(st0), .fifo_wr_en_o(en0), .rst_sig_o(rs0), .rst_sig_pulse_o(rsp0),
        .drain_to_o(dto0));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n clocks; inputs and samples sit 1ns after the rising edge
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [3:0] m);
        mask    = m;
        start_p = 1'b1;
        step();
        start_p = 1'b0;
    endtask

    initial begin
        // Reset
        step(2);
        chk("rst_state", st, 3'b000);
        chk("rst_en", en, 4'b0000);
        chk("rst_sig", rs, 1'b0);
        chk("rst_sigp", rsp, 1'b0);
        chk("rst_dto", dto, 1'b0);
        #2 rst_n = 1'b1;
        step();

        // Start, veto window, frame-aligned enables
        do_start(4'b1011);
        chk("arm_entry", st, 3'b010);
        chk("arm_sigp", rsp, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("arm_hold", st, 3'b010);
        end
        step();
        chk("run_entry", st, 3'b011);
        chk("run_en0", en, 4'b0000);
        fe = 4'b0001; step(); fe = 4'b0000;
        chk("run_fe0", en, 4'b0001);
        fe = 4'b0100; step(); fe = 4'b0000;
        chk("run_fe_masked", en, 4'b0001);
        fe = 4'b1010; step(); fe = 4'b0000;
        chk("run_fe13", en, 4'b1011);

        // Stop and staggered drain
        stop_p = 1'b1; step(); stop_p = 1'b0;
        chk("drn_entry", st, 3'b100);
        chk("drn_en_hold", en, 4'b1011);
        fe = 4'b0001; step(); fe = 4'b0000;
        chk("drn_drop0", en, 4'b1010);
        step();
        chk("drn_nofe", en, 4'b1010);
        fe = 4'b0010; step(); fe = 4'b0000;
        chk("drn_drop1", en, 4'b1000);
        fe = 4'b1000; step(); fe = 4'b0000;
        chk("drn_drop3", en, 4'b0000);
        chk("drn_still", st, 3'b100);
        step();
        chk("drn_idle", st, 3'b001);
        chk("drn_dto0", dto, 1'b0);

        // Drain timeout with channel 3 silent
        do_start(4'b1011);
        step(8);
        chk("to_run", st, 3'b011);
        fe = 4'b1011; step(); fe = 4'b0000;
        stop_p = 1'b1; step(); stop_p = 1'b0;
        fe = 4'b0011; step(); fe = 4'b0000;
        chk("to_en", en, 4'b1000);
        step(14);
        chk("to_pre_state", st, 3'b100);
        chk("to_pre_en", en, 4'b1000);
        step();
        chk("to_idle", st, 3'b001);
        chk("to_en0", en, 4'b0000);
        chk("to_dto", dto, 1'b1);
        do_start(4'b1011);
        chk("to_dto_clr", dto, 1'b0);

        // Restart in ARMING at counter 5
        step(5);
        do_start(4'b1011);
        chk("rearm", st, 3'b010);
        step(7);
        chk("rearm_hold", st, 3'b010);
        step();
        chk("rearm_run", st, 3'b011);
        fe = 4'b1111; step(); fe = 4'b0000;
        chk("rearm_en", en, 4'b1011);

        // Pulse priority
        start_p = 1'b1; stop_p = 1'b1; step(); start_p = 1'b0; stop_p = 1'b0;
        chk("prio_stop", st, 3'b100);
        rst_p = 1'b1; stop_p = 1'b1; step(); rst_p = 1'b0; stop_p = 1'b0;
        chk("prio_rst_st", st, 3'b001);
        chk("prio_rst_en", en, 4'b0000);
        chk("prio_rst_sigp", rsp, 1'b1);

        // Level commands and async reset mid-run
        do_start(4'b1011);
        step(8);
        fe = 4'b1111; step(); fe = 4'b0000;
        rst_l = 1'b1; step(); rst_l = 1'b0;
        chk("lvl_rst", rs, 1'b1);
        step();
        chk("lvl_rst_off", rs, 1'b0);
        start_l = 1'b1; step();
        chk("lvl_start", rs, 1'b1);
        chk("lvl_run", st, 3'b011);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", st, 3'b000);
        chk("arst_en", en, 4'b0000);
        chk("arst_sig", rs, 1'b0);
        start_l = 1'b0;
        #2 rst_n = 1'b1;
        step();

        // OFF -> IDLE via init, then unaligned variant
        init_p = 1'b1; step(); init_p = 1'b0;
        chk("init_idle", st, 3'b001);
        do_start(4'b0110);
        step(7);
        chk("na_arm_en", en0, 4'b0000);
        step();
        chk("na_run_st", st0, 3'b011);
        chk("na_run_en", en0, 4'b0110);
        chk("al_run_en", en, 4'b0000);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
